alu_issue_scheduler: RTL
========================

// Module: alu_issue_scheduler
// PURPOSE
//  Issue controller for the pipelined ALU. Accepts one ALU op per cycle over valid/ready.
//  Tracks in-flight ops in a LATENCY-deep scoreboard and stalls any op with a RAW hazard
//  on an in-flight destination. Emits a writeback tag aligned with ALUOut.
//  Sits between decode/ID-EX and the ALU + register-file writeback.
// PARAMETERS
//  LATENCY   4   cycles from issue handshake to ALUOut valid; legal range 1..8
//  CNT_W     16  width of the saturating hazard-stall counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  in_valid     in   1      op presented by decode
//  in_ready     out  1      scheduler accepts op this cycle
//  in_aluctl    in   7      ALUctl of presented op
//  in_rs1       in   5      source reg 1
//  in_rs1_used  in   1      op reads rs1
//  in_rs2       in   5      source reg 2
//  in_rs2_used  in   1      op reads rs2
//  in_rd        in   5      destination reg
//  in_rd_we     in   1      op writes rd
//  flush        in   1      kill all in-flight ops (branch taken / trap)
//  issue_valid  out  1      op launched into ALU this cycle (= in_valid & in_ready)
//  issue_aluctl out  7      ALUctl driven to ALU (= in_aluctl, combinational)
//  wb_valid     out  1      ALUOut holds a live result this cycle
//  wb_rd        out  5      destination of that result
//  wb_we        out  1      result must be written to wb_rd
//  busy         out  1      any scoreboard stage valid
//  stall_cnt    out  CNT_W  cycles lost to hazards, saturating
// BEHAVIOUR
//  - Scoreboard: stages S[1..LATENCY], each {v, rd, we}, all registers.
//    Every cycle S[k+1] <= S[k]; S[1] <= {issue, in_rd, in_rd_we & (in_rd != 0)}.
//  - Retire: wb_valid/wb_rd/wb_we = S[LATENCY] fields, driven straight from the registers.
//  - Latency: handshake in cycle t -> wb_valid=1 in cycle t+LATENCY, exactly one cycle.
//  - Hazard = (in_rs1_used & rs1!=0 & match(rs1)) | (in_rs2_used & rs2!=0 & match(rs2)).
//    match(r) = any k in 1..LATENCY with S[k].v & S[k].we & S[k].rd==r.
//    The stage being retired (S[LATENCY]) still counts, so no same-cycle WB forwarding.
//  - in_ready = !rst & !flush & !hazard. Combinational, does not depend on in_valid.
//  - A dependent op following its producer by one cycle stalls LATENCY cycles.
//    It issues LATENCY+1 cycles after the producer.
//  - Reads of x0 never hazard. Writes to x0 enter with we=0 and wb_we=0.
//  - in_valid may drop while stalled: no op is latched, nothing issues.
//  - flush in cycle t:
//      - no issue in cycle t;
//      - all S[k].v cleared at the edge ending t, so wb_valid=0 from t+1;
//      - the wb_* values already visible in cycle t are unaffected;
//      - stall_cnt is not incremented in cycle t.
//  - stall_cnt increments when in_valid & !flush & hazard. Saturates at 2^CNT_W-1, no wrap.
//  - busy = OR of S[k].v.
//  - Reset (async, any time, including mid-operation): all S[k] cleared, stall_cnt=0.
//    Outputs during reset: wb_valid=0, wb_rd=0, wb_we=0, busy=0, in_ready=0, issue_valid=0.
//    In-flight ops are dropped and never retire.
//  - Simultaneous issue + retire of the same rd: the new op occupies S[1].
//    The later op wins at writeback by ordering.
// TESTING
//  1 Independent ops, one per cycle (rd=1..8, no source overlap)
//    -> in_ready held 1; wb_valid at cycles t+4..t+11 with wb_rd=1..8.
//  2 add x5 at t, then sub reading x5 held valid from t+1
//    -> in_ready=0 for t+1..t+4; issue at t+5; stall_cnt=4.
//  3 Op writing x0, then op reading x0 next cycle
//    -> no stall; first retires with wb_we=0.
//  4 Three ops in flight, flush at t
//    -> no issue at t; wb_valid=0 from t+1; busy=0 at t+1; new op accepted at t+1.
//  5 rst pulsed asynchronously mid-cycle with 3 ops in flight
//    -> all outputs at reset values immediately; no wb_valid after release.
//  6 CNT_W=4, hazard stall held 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/alu_issue_scheduler.sv
// ALU issue scheduler: valid/ready issue with a LATENCY-deep scoreboard,
// RAW-hazard stalls, flush, and a writeback tag aligned with ALUOut.
module alu_issue_scheduler #(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_aluctl,
    input  logic [4:0]       in_rs1,
    input  logic             in_rs1_used,
    input  logic [4:0]       in_rs2,
    input  logic             in_rs2_used,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_we,
    input  logic             flush,
    output logic             issue_valid,
    output logic [6:0]       issue_aluctl,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             wb_we,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [LATENCY:1] sb_v;
    logic [LATENCY:1] sb_we;
    logic [4:0]       sb_rd [1:LATENCY];
    logic             hit1;
    logic             hit2;
    logic             hazard;

    // Source match against every live stage, retiring stage included.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 1; k <= LATENCY; k++) begin
            if (sb_v[k] && sb_we[k] && (sb_rd[k] == in_rs1))
                hit1 = 1'b1;
            if (sb_v[k] && sb_we[k] && (sb_rd[k] == in_rs2))
                hit2 = 1'b1;
        end
        hazard = (in_rs1_used && (in_rs1 != 5'd0) && hit1)
               || (in_rs2_used && (in_rs2 != 5'd0) && hit2);
    end

    assign in_ready     = !rst && !flush && !hazard;
    assign issue_valid  = in_valid && in_ready;
    assign issue_aluctl = in_aluctl;
    assign wb_valid     = sb_v[LATENCY];
    assign wb_rd        = sb_rd[LATENCY];
    assign wb_we        = sb_we[LATENCY];
    assign busy         = |sb_v;

    // Scoreboard shift; flush kills every live stage at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v  <= '0;
            sb_we <= '0;
            for (int k = 1; k <= LATENCY; k++)
                sb_rd[k] <= 5'd0;
        end else begin
            sb_v[1]  <= issue_valid;
            sb_rd[1] <= in_rd;
            sb_we[1] <= in_rd_we && (in_rd != 5'd0);
            for (int k = 2; k <= LATENCY; k++) begin
                sb_v[k]  <= sb_v[k-1] && !flush;
                sb_rd[k] <= sb_rd[k-1];
                sb_we[k] <= sb_we[k-1];
            end
        end
    end

    // Saturating count of cycles a presented op waits on a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (in_valid && !flush && hazard && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule
